// File: rtl/timer_channel_ctrl.sv
// timer_channel_ctrl: run/stop/one-shot sequencing, counter clear, TMO output, status flags
// and interrupt requests for one timer channel. Define TIMER_ADTRIG_EN to add the adtrg output.
module timer_channel_ctrl #(
   parameter int unsigned BIT_WIDTH = 8,
   parameter logic        TMO_INIT  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 count_tick,
   input  logic [BIT_WIDTH-1:0] tcnt,
   input  logic [BIT_WIDTH-1:0] tcora,
   input  logic [BIT_WIDTH-1:0] tcorb,
   input  logic [1:0]           cclr,
   input  logic [1:0]           os_a,
   input  logic [1:0]           os_b,
   input  logic                 oneshot,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 tmri,
   input  logic [2:0]           flag_clr,
   input  logic [2:0]           ie,
   output logic                 count_en,
   output logic                 counter_clear,
   output logic                 tmo,
   output logic                 cmfa,
   output logic                 cmfb,
   output logic                 ovf,
   output logic                 cmia,
   output logic                 cmib,
   output logic                 ovi,
`ifdef TIMER_ADTRIG_EN
   output logic                 adtrg,
`endif
   output logic [1:0]           run_state
);

   typedef enum logic [1:0] {
      ST_STOP = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t r_state;
   logic   r_tmri_s1, r_tmri_s2, r_tmri_d;
   logic   r_tmo, r_cmfa, r_cmfb, r_ovf;

   logic   w_run, w_cma_ev, w_cmb_ev, w_ovf_ev, w_tmri_ev, w_done_tr, w_clr;
   logic   w_tgl, w_high, w_low, w_tmo_nxt;

   assign w_run     = (r_state == ST_RUN);
   assign w_cma_ev  = w_run & count_tick & (tcnt == tcora);
   assign w_cmb_ev  = w_run & count_tick & (tcnt == tcorb);
   assign w_tmri_ev = r_tmri_s2 & ~r_tmri_d;
   assign w_done_tr = w_run & oneshot & w_cma_ev & ~stop;

   always_comb begin
      w_clr = 1'b0;
      case (cclr)
         2'b01:   w_clr = w_cma_ev;
         2'b10:   w_clr = w_cmb_ev;
         2'b11:   w_clr = w_tmri_ev;
         default: w_clr = 1'b0;
      endcase
      if (w_done_tr) w_clr = 1'b1;
   end

   // A clear on the all-ones count is a wrap, not an overflow
   assign w_ovf_ev = w_run & count_tick & (tcnt == '1) & ~w_clr;

   always_comb begin
      w_tgl  = (w_cma_ev && os_a == 2'b11) || (w_cmb_ev && os_b == 2'b11);
      w_high = (w_cma_ev && os_a == 2'b10) || (w_cmb_ev && os_b == 2'b10);
      w_low  = (w_cma_ev && os_a == 2'b01) || (w_cmb_ev && os_b == 2'b01);
      w_tmo_nxt = r_tmo;
      if (w_tgl)       w_tmo_nxt = ~r_tmo;
      else if (w_high) w_tmo_nxt = 1'b1;
      else if (w_low)  w_tmo_nxt = 1'b0;
   end

   // Stop takes precedence over start in every state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_STOP;
      end else begin
         case (r_state)
            ST_STOP: if (start && !stop) r_state <= ST_RUN;
            ST_RUN: begin
               if (stop)                       r_state <= ST_STOP;
               else if (oneshot && w_cma_ev)   r_state <= ST_DONE;
            end
            ST_DONE: begin
               if (stop)       r_state <= ST_STOP;
               else if (start) r_state <= ST_RUN;
            end
            default: r_state <= ST_STOP;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmri_s1 <= 1'b0;
         r_tmri_s2 <= 1'b0;
         r_tmri_d  <= 1'b0;
         r_tmo     <= TMO_INIT;
         r_cmfa    <= 1'b0;
         r_cmfb    <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_tmri_s1 <= tmri;
         r_tmri_s2 <= r_tmri_s1;
         r_tmri_d  <= r_tmri_s2;
         r_tmo     <= w_tmo_nxt;
         r_cmfa    <= w_cma_ev | (r_cmfa & ~flag_clr[0]);
         r_cmfb    <= w_cmb_ev | (r_cmfb & ~flag_clr[1]);
         r_ovf     <= w_ovf_ev | (r_ovf  & ~flag_clr[2]);
      end
   end

`ifdef TIMER_ADTRIG_EN
   logic r_adtrg;
   always_ff @(posedge clk) begin
      if (rst) r_adtrg <= 1'b0;
      else     r_adtrg <= w_cma_ev;
   end
   assign adtrg = r_adtrg;
`endif

   assign count_en      = w_run;
   assign counter_clear = w_clr;
   assign tmo           = r_tmo;
   assign cmfa          = r_cmfa;
   assign cmfb          = r_cmfb;
   assign ovf           = r_ovf;
   assign cmia          = r_cmfa & ie[0];
   assign cmib          = r_cmfb & ie[1];
   assign ovi           = r_ovf  & ie[2];
   assign run_state     = r_state;

endmodule

// File: tb/tb_timer_channel_ctrl.sv
// Self-checking bench for timer_channel_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a behavioural channel model.
module tb_timer_channel_ctrl;

   logic       clk, rst, count_tick, oneshot, start, stop, tmri;
   logic [7:0] tcnt, tcora, tcorb;
   logic [1:0] cclr, os_a, os_b;
   logic [2:0] flag_clr, ie;
   logic       count_en, counter_clear, tmo, cmfa, cmfb, ovf, cmia, cmib, ovi;
   logic [1:0] run_state;
`ifdef TIMER_ADTRIG_EN
   logic       adtrg;
`endif

   timer_channel_ctrl #(.BIT_WIDTH(8), .TMO_INIT(1'b0)) dut (
      .clk(clk), .rst(rst), .count_tick(count_tick), .tcnt(tcnt), .tcora(tcora), .tcorb(tcorb),
      .cclr(cclr), .os_a(os_a), .os_b(os_b), .oneshot(oneshot), .start(start), .stop(stop),
      .tmri(tmri), .flag_clr(flag_clr), .ie(ie), .count_en(count_en),
      .counter_clear(counter_clear), .tmo(tmo), .cmfa(cmfa), .cmfb(cmfb), .ovf(ovf),
      .cmia(cmia), .cmib(cmib), .ovi(ovi),
`ifdef TIMER_ADTRIG_EN
      .adtrg(adtrg),
`endif
      .run_state(run_state));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned n_cc  = 0;

   // model: state 0=STOP 1=RUN 2=DONE, flags, tmo, tmri sample history, external counter
   bit         m_valid = 0;
   int         m_state;
   bit         m_tmo, m_cmfa, m_cmfb, m_ovf, m_adtrg;
   bit         m_h0, m_h1, m_h2;
   logic [7:0] m_cnt;
   bit         use_cnt;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      bit run, cma, cmb, tev, cc, ove;
      int act_a, act_b, act;
      if (use_cnt) tcnt = m_cnt;
      #1;
      run = (m_state == 1);
      cma = run && count_tick && (tcnt == tcora);
      cmb = run && count_tick && (tcnt == tcorb);
      tev = m_h1 && !m_h2;
      case (cclr)
         2'd1:    cc = cma;
         2'd2:    cc = cmb;
         2'd3:    cc = tev;
         default: cc = 0;
      endcase
      if (run && oneshot && cma && !stop) cc = 1;
      ove = run && count_tick && (tcnt == 8'hFF) && !cc;
      if (m_valid) begin
         chk("count_en", {7'd0, count_en}, {7'd0, run});
         chk("counter_clear", {7'd0, counter_clear}, {7'd0, cc});
         chk("tmo", {7'd0, tmo}, {7'd0, m_tmo});
         chk("cmfa", {7'd0, cmfa}, {7'd0, m_cmfa});
         chk("cmfb", {7'd0, cmfb}, {7'd0, m_cmfb});
         chk("ovf", {7'd0, ovf}, {7'd0, m_ovf});
         chk("cmia", {7'd0, cmia}, {7'd0, m_cmfa & ie[0]});
         chk("cmib", {7'd0, cmib}, {7'd0, m_cmfb & ie[1]});
         chk("ovi", {7'd0, ovi}, {7'd0, m_ovf & ie[2]});
         chk("run_state", {6'd0, run_state}, 8'(m_state));
`ifdef TIMER_ADTRIG_EN
         chk("adtrg", {7'd0, adtrg}, {7'd0, m_adtrg});
`endif
         if (counter_clear === 1'b1) n_cc++;
      end
      if (rst) begin
         m_valid = 1; m_state = 0; m_tmo = 0; m_cmfa = 0; m_cmfb = 0; m_ovf = 0;
         m_adtrg = 0; m_h0 = 0; m_h1 = 0; m_h2 = 0; m_cnt = 8'd0;
      end else begin
         if (stop)                            m_state = 0;
         else if (m_state == 0 && start)      m_state = 1;
         else if (m_state == 1 && oneshot && cma) m_state = 2;
         else if (m_state == 2 && start)      m_state = 1;
         // encodings none<low<high<toggle rank by value, so the stronger action is the max
         act_a = cma ? int'(os_a) : 0;
         act_b = cmb ? int'(os_b) : 0;
         act = (act_a > act_b) ? act_a : act_b;
         if (act == 3)      m_tmo = !m_tmo;
         else if (act == 2) m_tmo = 1;
         else if (act == 1) m_tmo = 0;
         m_cmfa = cma || (m_cmfa && !flag_clr[0]);
         m_cmfb = cmb || (m_cmfb && !flag_clr[1]);
         m_ovf  = ove || (m_ovf && !flag_clr[2]);
         m_adtrg = cma;
         m_h2 = m_h1; m_h1 = m_h0; m_h0 = tmri;
         if (cc) m_cnt = 8'd0;
         else if (run && count_tick) m_cnt = m_cnt + 8'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1; start = 0; stop = 0; flag_clr = 3'd0;
      step();
      rst = 0;
   endtask

   task automatic pulse_start();
      start = 1; step(); start = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1; count_tick = 1; tcnt = 0; tcora = 0; tcorb = 8'h80; cclr = 0; os_a = 0; os_b = 0;
      oneshot = 0; start = 0; stop = 0; tmri = 0; flag_clr = 0; ie = 3'b111; use_cnt = 1;
      m_cnt = 0; m_state = 0;
      step();
      chk("reset_run_state", {6'd0, run_state}, 8'h00);
      chk("reset_tmo", {7'd0, tmo}, 8'h00);
      rst = 0;

      // clear on A with toggle
      tcora = 8'h05; cclr = 2'b01; os_a = 2'b11; ie = 3'b001;
      pulse_start();
      repeat (6) step();
      chk("clrA_tmo1", {7'd0, tmo}, 8'h01);
      chk("clrA_cmia", {7'd0, cmia}, 8'h01);
      repeat (6) step();
      chk("clrA_tmo0", {7'd0, tmo}, 8'h00);
      flag_clr = 3'b001; step(); flag_clr = 0;
      chk("clrA_cmfa_clr", {7'd0, cmfa}, 8'h00);

      // overflow, then wrap with clear on A at 0xFF
      do_reset();
      cclr = 2'b00; os_a = 0; tcora = 8'h05; tcorb = 8'h80; ie = 3'b100;
      pulse_start();
      m_cnt = 8'hFE; repeat (2) step();
      chk("ovf_set", {7'd0, ovf}, 8'h01);
      chk("ovi_set", {7'd0, ovi}, 8'h01);
      flag_clr = 3'b111; step(); flag_clr = 0;
      cclr = 2'b01; tcora = 8'hFF;
      m_cnt = 8'hFE; repeat (2) step();
      chk("wrap_ovf", {7'd0, ovf}, 8'h00);
      chk("wrap_cmfa", {7'd0, cmfa}, 8'h01);

      // simultaneous A/B: toggle beats low
      do_reset();
      cclr = 2'b00; tcora = 8'h10; tcorb = 8'h10; os_a = 2'b01; os_b = 2'b11;
      pulse_start();
      m_cnt = 8'h0F; repeat (2) step();
      chk("simul_tmo", {7'd0, tmo}, 8'h01);

      // one-shot
      do_reset();
      os_a = 0; os_b = 0; tcorb = 8'h80; tcora = 8'h03; oneshot = 1;
      pulse_start();
      repeat (4) step();
      chk("os_done", {6'd0, run_state}, 8'h02);
      chk("os_count_en", {7'd0, count_en}, 8'h00);
      pulse_start();
      chk("os_restart", {6'd0, run_state}, 8'h01);
      oneshot = 0;

      // TMRI clear: a single pulse for a held-high pin
      do_reset();
      cclr = 2'b11; tcora = 8'h05; count_tick = 0;
      pulse_start();
      m_cnt = 8'h40; n_cc = 0; tmri = 1;
      repeat (8) step();
      chk("tmri_pulses", 8'(n_cc), 8'h01);
      tmri = 0; count_tick = 1;

      // flag race and start/stop collision
      do_reset();
      cclr = 2'b00; tcora = 8'h03;
      pulse_start();
      m_cnt = 8'h03; flag_clr = 3'b001; step(); flag_clr = 0;
      chk("race_cmfa", {7'd0, cmfa}, 8'h01);
      start = 1; stop = 1; step(); start = 0; stop = 0;
      chk("startstop", {6'd0, run_state}, 8'h00);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 15) == 0);
         stop = ($urandom_range(0, 31) == 0);
         count_tick = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 63) == 0) begin
            cclr = 2'($urandom_range(0, 3));
            os_a = 2'($urandom_range(0, 3));
            os_b = 2'($urandom_range(0, 3));
            oneshot = ($urandom_range(0, 3) == 0);
            ie = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
               0: tcora = 8'hFF;
               1: tcora = 8'($urandom_range(0, 15));
               default: tcora = 8'($urandom_range(0, 255));
            endcase
            tcorb = ($urandom_range(0, 2) == 0) ? tcora : 8'($urandom_range(0, 255));
            use_cnt = ($urandom_range(0, 1) == 1);
         end
         if ($urandom_range(0, 7) == 0) tmri = ~tmri;
         flag_clr = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
         if (use_cnt) begin
            if ($urandom_range(0, 99) == 0) m_cnt = 8'($urandom_range(0, 255));
         end else begin
            case ($urandom_range(0, 3))
               0: tcnt = tcora;
               1: tcnt = tcorb;
               2: tcnt = 8'hFF;
               default: tcnt = 8'($urandom_range(0, 255));
            endcase
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/timer_channel_ctrl.md
Name: timer_channel_ctrl

Overview:
- Per-channel control unit for one 8-bit timer channel; one instance per channel (TMO0..TMO3).
- Sequences the counter through run/stop/one-shot states and generates counter clear and compare-match output (TMOn).
- Maintains the CMFA/CMFB/OVF status flags and raises interrupt requests.
- Sits between the channel's counter/comparators and the register file; the register file supplies the configuration fields.

Parameters:
- BIT_WIDTH, 8, counter/constant register width.
- TMO_INIT, 1'b0, value of tmo after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- count_tick  in  1  counter clock-edge event from clock select; one cycle per count.
- tcnt  in  BIT_WIDTH  current counter value.
- tcora  in  BIT_WIDTH  constant register A.
- tcorb  in  BIT_WIDTH  constant register B.
- cclr  in  2  clear select: 00 none, 01 on CMA, 10 on CMB, 11 on TMRI rising edge.
- os_a  in  2  output action on CMA: 00 none, 01 low, 10 high, 11 toggle.
- os_b  in  2  output action on CMB; same encoding as os_a.
- oneshot  in  1  stop after the first CMA event.
- start  in  1  start request pulse.
- stop  in  1  stop request pulse.
- tmri  in  1  asynchronous external reset pin.
- flag_clr  in  3  write-1-to-clear for {ovf, cmfb, cmfa}.
- ie  in  3  interrupt enables for {ovi, cmib, cmia}.
- count_en  out  1  counter increments only when 1.
- counter_clear  out  1  counter loads 0 this cycle.
- tmo  out  1  compare-match output pin.
- cmfa  out  1  compare-match A flag.
- cmfb  out  1  compare-match B flag.
- ovf  out  1  overflow flag.
- cmia  out  1  interrupt request A.
- cmib  out  1  interrupt request B.
- ovi  out  1  overflow interrupt request.
- run_state  out  2  00 STOP, 01 RUN, 10 DONE.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. Everything updates on the rising edge of clk.
- Reset values: state=STOP, tmo=TMO_INIT, all flags 0, synchronizer and edge registers 0. Therefore count_en=0, counter_clear=0, and all irq outputs are 0.
- State machine:
  - STOP: start -> RUN.
  - RUN: stop -> STOP; otherwise, if oneshot and cma_ev -> DONE.
  - DONE: start -> RUN; stop -> STOP.
  - If start and stop arrive in the same cycle, stop wins.
  - count_en = (state==RUN), combinational from state.
- Events, combinational, evaluated only while count_en=1:
  - cma_ev = count_tick & (tcnt==tcora).
  - cmb_ev = count_tick & (tcnt==tcorb).
  - ovf_ev = count_tick & (tcnt=={BIT_WIDTH{1}}) & ~counter_clear.
- TMRI handling: two-flop synchronizer, then rising-edge detect, giving tmri_ev (3-cycle latency from pin to event). tmri_ev is honoured in any state.
- counter_clear, combinational, same cycle as the event:
  - cclr=01: counter_clear = cma_ev.
  - cclr=10: counter_clear = cmb_ev.
  - cclr=11: counter_clear = tmri_ev.
  - Additionally, counter_clear=1 on the RUN->DONE transition.
  - Clear overrides increment.
- tmo, registered, updates the cycle after the event:
  - If both events occur in one cycle, the applied action has priority toggle > high > low.
  - A "none" action from one source does not mask an action from the other.
- Flags:
  - A flag sets the cycle after its event.
  - flag_clr bit=1 clears the flag.
  - Set and clear in the same cycle: set wins.
- Interrupts: cmia = cmfa & ie[0], cmib = cmfb & ie[1], ovi = ovf & ie[2]. All combinational from the flag registers.
- Wrap-around: with tcora=0xFF and cclr=01, both cma_ev and the clear occur, and ovf_ev is suppressed (no OVF).
- Reset mid-count: rst returns everything to reset values regardless of pending events.

Optional Feature:
- Macro: TIMER_ADTRIG_EN.
- When defined: adds output adtrg (1 bit), a registered one-cycle pulse the cycle after each cma_ev; reset value 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Clear on A: rst; start; cclr=01, tcora=0x05, os_a=11, tick every cycle -> counter_clear high when tcnt=0x05; tmo toggles every 6 ticks; cmfa=1; with ie[0]=1, cmia=1 until flag_clr[0] pulse.
- Overflow: cclr=00 -> at tcnt=0xFF with tick, ovf sets next cycle. Next, cclr=01 with tcora=0xFF -> ovf stays 0, cmfa=1.
- Simultaneous A/B: tcora=tcorb=0x10, os_a=01, os_b=11, tmo=0 -> tmo=1 after the match (toggle wins).
- One-shot: oneshot=1, tcora=0x03 -> run_state goes 01->10 at the match, counter_clear pulses, count_en=0. A later start returns run_state to 01.
- TMRI: cclr=11, raise tmri while tcnt=0x40 -> counter_clear is a single-cycle pulse 3 cycles later. Holding tmri high gives no further pulses.
- Flag race: cma_ev and flag_clr[0] in the same cycle -> cmfa=1. With stop and start asserted together in RUN -> run_state=00.
